// File: rtl/add_serial_pkg.sv
// Shared definitions for the add_serial operand sequencer: FSM state encoding
// and default sizing for the serial adder datapath.
package add_serial_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_ADD_LAT    = 9;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_RELEASE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/add_serial_fifo.sv
// Synchronous FIFO holding packed operand pairs; no bypass, so a word pushed
// into an empty FIFO is visible on pop_data only from the following cycle.
module add_serial_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/add_serial_seq.sv
// Feeds buffered operand pairs one at a time into the add_serial bit-serial
// adder, waits out its latency and hands the sum to a valid/ready result port.
module add_serial_seq
    import add_serial_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADD_LAT    = DEF_ADD_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             add_en,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             busy
);

    localparam int CW = $clog2(ADD_LAT);
    localparam logic [CW-1:0] LAT_LAST = CW'(ADD_LAT - 1);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [CW-1:0]      lat_cnt;
    logic               lat_clr;
    logic               lat_inc;
    logic               capture;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*WIDTH-1:0] fifo_rd_data;

    assign push     = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && !fifo_empty;
    assign in_ready = !fifo_full;

    add_serial_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_a, in_b}),
        .pop       (pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A finished sum may only overwrite the result register once the previous
    // one has been taken; until then the adder keeps holding it in DONE.
    always_comb begin
        state_next = state;
        lat_clr    = 1'b0;
        lat_inc    = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                lat_clr    = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_next = S_CAPTURE;
                end else begin
                    lat_inc = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (!res_valid || res_ready) begin
                    capture    = 1'b1;
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (lat_clr) begin
            lat_cnt <= '0;
        end else if (lat_inc) begin
            lat_cnt <= lat_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a <= '0;
            add_b <= '0;
        end else if (pop) begin
            {add_a, add_b} <= fifo_rd_data;
        end
    end

    // A capture in the same cycle as an accept keeps res_valid asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_sum   <= '0;
            res_valid <= 1'b0;
        end else if (capture) begin
            res_sum   <= add_out;
            res_valid <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign add_en = (state == S_START) || (state == S_RELEASE);
    assign busy   = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_add_serial_seq.sv
// Directed bench for add_serial_seq with a behavioural serial-adder model that
// only shows the true sum ADD_LAT cycles after sampling add_en.
module tb_add_serial_seq;
    import add_serial_pkg::*;

    localparam int WIDTH   = 8;
    localparam int ADD_LAT = 9;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             add_en;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [WIDTH-1:0] got[$];
    int               vld_cyc[$];
    int               en_cyc[$];

    add_serial_seq #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (4),
        .ADD_LAT    (ADD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Adder model: IDLE -> RUN on add_en, out shows a wrong value until the
    // sum becomes final, DONE holds it until the releasing add_en.
    logic [1:0]       mdl_st;
    int               mdl_cnt;
    logic [WIDTH-1:0] mdl_sum;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_st  <= 2'd0;
            mdl_cnt <= 0;
            mdl_sum <= '0;
            add_out <= '0;
        end else begin
            case (mdl_st)
                2'd0: if (add_en) begin
                    mdl_sum <= add_a + add_b;
                    add_out <= ~(add_a + add_b);
                    mdl_cnt <= 0;
                    mdl_st  <= 2'd1;
                end
                2'd1: if (mdl_cnt == ADD_LAT - 1) begin
                    add_out <= mdl_sum;
                    mdl_st  <= 2'd2;
                end else begin
                    mdl_cnt <= mdl_cnt + 1;
                end
                2'd2: if (add_en) mdl_st <= 2'd0;
                default: mdl_st <= 2'd0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid && res_ready) begin
                got.push_back(res_sum);
                vld_cyc.push_back(cyc);
            end
            if (add_en) en_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
        int t = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && t < 64) begin
            @(posedge clk);
            #1;
            t++;
        end
        checkOutput(tag, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idleInput();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
    endtask

    task automatic clearLogs();
        got.delete();
        vld_cyc.delete();
        en_cyc.delete();
    endtask

    function automatic logic [WIDTH-1:0] sumAt(input int i);
        return (i < got.size()) ? got[i] : 'x;
    endfunction

    function automatic int cycAt(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1000;
    endfunction

    initial begin
        int push_cyc;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b1;

        // 1: asynchronous reset asserted mid-cycle
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_add_en", 32'(add_en), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_add_a", 32'(add_a), 32'd0);
        checkOutput("rst_add_b", 32'(add_b), 32'd0);
        checkOutput("rst_res_sum", 32'(res_sum), 32'd0);
        waitCycles(2);
        rst = 1'b0;
        waitCycles(2);
        clearLogs();

        // 2: single op, timing of add_en and res_valid
        applyStimulus(8'h35, 8'h4A, "t2_accept");
        push_cyc = cyc;
        idleInput();
        waitCycles(20);
        checkOutput("t2_en_count", 32'(en_cyc.size()), 32'd2);
        checkOutput("t2_en_gap", 32'(cycAt(en_cyc, 1) - cycAt(en_cyc, 0) - 1), 32'd10);
        checkOutput("t2_vld_count", 32'(vld_cyc.size()), 32'd1);
        checkOutput("t2_vld_latency", 32'(cycAt(vld_cyc, 0) - push_cyc), 32'd12);
        checkOutput("t2_sum", 32'(sumAt(0)), 32'h7F);
        checkOutput("t2_hold_a", 32'(add_a), 32'h35);
        checkOutput("t2_idle_busy", 32'(busy), 32'd0);
        clearLogs();

        // 3 and 4: wrap-around and discarded carry
        applyStimulus(8'hFF, 8'h01, "t3_accept");
        idleInput();
        waitCycles(20);
        checkOutput("t3_sum_wrap", 32'(sumAt(0)), 32'h00);
        checkOutput("t3_count", 32'(got.size()), 32'd1);
        clearLogs();
        applyStimulus(8'h80, 8'h80, "t4_accept");
        idleInput();
        waitCycles(20);
        checkOutput("t4_sum_carry", 32'(sumAt(0)), 32'h00);
        clearLogs();

        // 5: backpressure fills the FIFO and parks the FSM
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 8'(2 * i), "t5_accept");
        end
        in_a     = 8'd6;
        in_b     = 8'd12;
        in_valid = 1'b1;
        checkOutput("t5_full_in_ready", 32'(in_ready), 32'd0);
        waitCycles(1);
        idleInput();
        waitCycles(40);
        checkOutput("t5_parked_state", 32'(dut.state), 32'(S_CAPTURE));
        checkOutput("t5_parked_valid", 32'(res_valid), 32'd1);
        checkOutput("t5_parked_sum", 32'(res_sum), 32'h03);
        checkOutput("t5_parked_busy", 32'(busy), 32'd1);
        checkOutput("t5_parked_none", 32'(got.size()), 32'd0);
        res_ready = 1'b1;
        waitCycles(70);
        checkOutput("t5_drain_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t5_drain_sum%0d", i), 32'(sumAt(i)), 32'(3 * (i + 1)));
        end
        applyStimulus(8'd6, 8'd12, "t5_sixth_accept");
        idleInput();
        waitCycles(20);
        checkOutput("t5_sixth_sum", 32'(sumAt(5)), 32'h12);
        clearLogs();

        // 6: back-to-back throughput
        applyStimulus(8'h11, 8'h22, "t6_accept0");
        applyStimulus(8'h40, 8'h05, "t6_accept1");
        applyStimulus(8'hA0, 8'h70, "t6_accept2");
        idleInput();
        waitCycles(50);
        checkOutput("t6_count", 32'(vld_cyc.size()), 32'd3);
        checkOutput("t6_gap01", 32'(cycAt(vld_cyc, 1) - cycAt(vld_cyc, 0)), 32'd13);
        checkOutput("t6_gap12", 32'(cycAt(vld_cyc, 2) - cycAt(vld_cyc, 1)), 32'd13);
        checkOutput("t6_sum0", 32'(sumAt(0)), 32'h33);
        checkOutput("t6_sum1", 32'(sumAt(1)), 32'h45);
        checkOutput("t6_sum2", 32'(sumAt(2)), 32'h10);
        clearLogs();

        // 7: reset during S_WAIT with two pairs queued
        applyStimulus(8'h10, 8'h20, "t7_accept0");
        applyStimulus(8'h01, 8'h01, "t7_accept1");
        applyStimulus(8'h02, 8'h02, "t7_accept2");
        idleInput();
        waitCycles(3);
        checkOutput("t7_in_wait", 32'(dut.state), 32'(S_WAIT));
        #2 rst = 1'b1;
        #1;
        checkOutput("t7_rst_valid", 32'(res_valid), 32'd0);
        checkOutput("t7_rst_busy", 32'(busy), 32'd0);
        checkOutput("t7_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("t7_rst_add_en", 32'(add_en), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        clearLogs();
        waitCycles(20);
        checkOutput("t7_no_result", 32'(vld_cyc.size()), 32'd0);
        checkOutput("t7_no_start", 32'(en_cyc.size()), 32'd0);
        applyStimulus(8'h01, 8'h02, "t7_accept_next");
        idleInput();
        waitCycles(20);
        checkOutput("t7_next_count", 32'(got.size()), 32'd1);
        checkOutput("t7_next_sum", 32'(sumAt(0)), 32'h03);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
